// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Main-memory model that sits behind the L2 line refill/writeback interface.
// It accepts one line request at a time. A refill read waits LATENCY cycles
// and then streams the line out in word beats, offset 0 first. A writeback
// takes WORDS_PER_LINE beats, waits LATENCY cycles and then pulses wr_done.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready line request handshake (accepted only in IDLE)
//   req_write           1 = writeback, 0 = refill read
//   req_addr            byte address; word-offset and byte bits ignored,
//                       line index aliases modulo DEPTH_LINES
//   wdata/_valid/_ready writeback beat stream
//   rdata/_valid/_last  refill beat stream, rdata_ready is the cache's ready
//   wr_done             one-cycle writeback acknowledge
//
// Every output is a register. The next-state logic computes the next value of
// each output, so nothing combinational reaches a port.
//
// The storage array has no reset and no power-up value of its own; simulation
// environments preload it (word k = k by convention).
// -----------------------------------------------------------------------------
module mem_line_responder #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int DEPTH_LINES    = 256,
  parameter int LATENCY        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  rdata_last,
  input  logic                  rdata_ready,
  output logic                  wr_done
);

  localparam int BYTE_W    = $clog2(WORD_WIDTH / 8);
  localparam int OFF_W     = $clog2(WORDS_PER_LINE);
  localparam int IDX_W     = $clog2(DEPTH_LINES);
  localparam int LAT_W     = $clog2(LATENCY + 1);
  localparam int MEM_WORDS = DEPTH_LINES * WORDS_PER_LINE;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0] LAT_END   = LAT_W'(LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT,
    WR_ACK
  } state_t;

  logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

  state_t             state, state_d;
  logic [OFF_W-1:0]   beat_cnt, beat_d;
  logic [LAT_W-1:0]   lat_cnt, lat_d;
  logic [IDX_W-1:0]   line_idx, idx_d;
  logic               mem_we;

  logic                  req_ready_d;
  logic                  wdata_ready_d;
  logic                  rdata_valid_d;
  logic                  rdata_last_d;
  logic [WORD_WIDTH-1:0] rdata_d;
  logic                  wr_done_d;

  // Only the line-index field of the address is decoded; the remaining bits
  // are deliberately dropped (offset is always 0, upper bits alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    state_d = state;
    beat_d  = beat_cnt;
    lat_d   = lat_cnt;
    idx_d   = line_idx;
    mem_we  = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          idx_d   = req_addr[BYTE_W+OFF_W +: IDX_W];
          beat_d  = '0;
          lat_d   = '0;
          state_d = req_write ? WR_BURST : RD_WAIT;
        end
      end

      // The counter stops at LATENCY, so it saturates rather than wraps.
      // Leaving after it has reached LATENCY puts the first beat on the
      // bus LATENCY+1 cycles after the accept edge.
      RD_WAIT: begin
        if (lat_cnt == LAT_END) state_d = RD_BURST;
        else                    lat_d   = lat_cnt + LAT_W'(1);
      end

      RD_BURST: begin
        if (rdata_valid && rdata_ready) begin
          if (beat_cnt == LAST_BEAT) state_d = IDLE;
          else                       beat_d  = beat_cnt + OFF_W'(1);
        end
      end

      WR_BURST: begin
        if (wdata_valid && wdata_ready) begin
          mem_we = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state_d = WR_WAIT;
            lat_d   = '0;
          end else begin
            beat_d = beat_cnt + OFF_W'(1);
          end
        end
      end

      WR_WAIT: begin
        if (lat_cnt == LAT_END) state_d = WR_ACK;
        else                    lat_d   = lat_cnt + LAT_W'(1);
      end

      WR_ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Outputs are a pure function of the next state, so registering them
    // makes each one line up with the state it describes. While a refill beat
    // is stalled, beat_d and the array are unchanged, so rdata/rdata_last hold.
    req_ready_d   = (state_d == IDLE);
    wdata_ready_d = (state_d == WR_BURST);
    rdata_valid_d = (state_d == RD_BURST);
    wr_done_d     = (state_d == WR_ACK);
    rdata_last_d  = (state_d == RD_BURST) && (beat_d == LAST_BEAT);
    rdata_d       = (state_d == RD_BURST) ? mem[{idx_d, beat_d}] : '0;
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      lat_cnt     <= '0;
      line_idx    <= '0;
      req_ready   <= 1'b1;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata_last  <= 1'b0;
      rdata       <= '0;
      wr_done     <= 1'b0;
    end else begin
      state       <= state_d;
      beat_cnt    <= beat_d;
      lat_cnt     <= lat_d;
      line_idx    <= idx_d;
      req_ready   <= req_ready_d;
      wdata_ready <= wdata_ready_d;
      rdata_valid <= rdata_valid_d;
      rdata_last  <= rdata_last_d;
      rdata       <= rdata_d;
      wr_done     <= wr_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset. Clearing it would need
  // a per-word reset network, and a reset mid-writeback must keep the beats
  // already written. Reset only blocks a write landing on the reset edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[{line_idx, beat_cnt}] <= wdata;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_line_responder
//
// Directed bench for mem_line_responder with default parameters
// (32-bit words, 4 words per line, 256 lines, LATENCY = 4).
// A per-cycle vector table covers reset and a plain refill of line 1.
// Hand-written sequences then cover backpressure, writeback and readback,
// aliasing with an ignored request, reset arriving together with a request,
// and reset in the middle of a writeback.
// Inputs change 1 time unit after a rising edge, and outputs are sampled at
// that same point.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;

  localparam int WW  = 32;
  localparam int AW  = 32;
  localparam int WPL = 4;
  localparam int DL  = 256;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] wdata;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [WW-1:0] rdata;
  logic          rdata_valid;
  logic          rdata_last;
  logic          rdata_ready;
  logic          wr_done;

  mem_line_responder #(
    .WORD_WIDTH     (WW),
    .ADDR_WIDTH     (AW),
    .WORDS_PER_LINE (WPL),
    .DEPTH_LINES    (DL),
    .LATENCY        (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .rdata_last  (rdata_last),
    .rdata_ready (rdata_ready),
    .wr_done     (wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef logic [31:0] line_t [WPL];

  typedef struct packed {
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic        rdata_ready;
    logic        e_req_ready;
    logic        e_wdata_ready;
    logic        e_rdata_valid;
    logic        e_rdata_last;
    logic [31:0] e_rdata;
    logic        e_wr_done;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic rv, input logic rw,
                              input logic [31:0] a, input logic rdy,
                              input logic err, input logic ewr, input logic erv,
                              input logic erl, input logic [31:0] erd,
                              input logic edn);
    vec_t v;
    v.rst = r; v.req_valid = rv; v.req_write = rw; v.req_addr = a;
    v.rdata_ready = rdy; v.e_req_ready = err; v.e_wdata_ready = ewr;
    v.e_rdata_valid = erv; v.e_rdata_last = erl; v.e_rdata = erd;
    v.e_wr_done = edn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd1);
    check({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
    check({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    check({tag, "_rdata_last"},  32'(rdata_last),  32'd0);
    check({tag, "_rdata"},       rdata,            32'd0);
    check({tag, "_wr_done"},     32'(wr_done),     32'd0);
  endtask

  // Issue a refill read and check latency, beat order, last flag, optional
  // stall on one beat, optional extra req_valid pulse during the burst, and
  // that no further beats follow.
  task automatic read_line(input logic [31:0] addr, input line_t exp_w,
                           input int stall_beat, input int stall_cycles,
                           input bit poke);
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = addr;
    rdata_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check("rd_accept_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      step();
      check("rd_wait_valid", 32'(rdata_valid), 32'd0);
    end
    step();
    for (int b = 0; b < WPL; b++) begin
      check("rd_valid", 32'(rdata_valid), 32'd1);
      check("rd_data",  rdata,            exp_w[b]);
      check("rd_last",  32'(rdata_last),  32'(b == WPL - 1));
      if (b == stall_beat) begin
        rdata_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          check("rd_stall_valid", 32'(rdata_valid), 32'd1);
          check("rd_stall_data",  rdata,            exp_w[b]);
          check("rd_stall_last",  32'(rdata_last),  32'(b == WPL - 1));
        end
        rdata_ready = 1'b1;
      end
      if (poke && b == 1) begin
        req_valid = 1'b1;
        req_addr  = addr;
      end
      step();
      req_valid = 1'b0;
    end
    check("rd_end_valid",     32'(rdata_valid), 32'd0);
    check("rd_end_req_ready", 32'(req_ready),   32'd1);
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      check("rd_idle_valid", 32'(rdata_valid), 32'd0);
    end
  endtask

  task automatic write_line(input logic [31:0] addr, input line_t data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    check("wr_accept_req_ready", 32'(req_ready),   32'd0);
    for (int b = 0; b < WPL; b++) begin
      check("wr_wdata_ready", 32'(wdata_ready), 32'd1);
      wdata       = data[b];
      wdata_valid = 1'b1;
      step();
    end
    wdata_valid = 1'b0;
    check("wr_after_wdata_ready", 32'(wdata_ready), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      step();
      check("wr_wait_done", 32'(wr_done), 32'd0);
    end
    step();
    check("wr_done_pulse", 32'(wr_done), 32'd1);
    step();
    check("wr_done_clear",     32'(wr_done),   32'd0);
    check("wr_end_req_ready",  32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_t exp_line;
    line_t a_line;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    wdata       = '0;
    wdata_valid = 1'b0;
    rdata_ready = 1'b1;

    for (int k = 0; k < DL * WPL; k++) dut.mem[k] = 32'(k);

    // Vector table: inputs applied, one edge, then outputs compared.
    vecs[0]  = mk(1, 0, 0, 32'h0,  1, 1, 0, 0, 0, 32'd0, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,  1, 1, 0, 0, 0, 32'd0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,  1, 1, 0, 0, 0, 32'd0, 0);
    vecs[3]  = mk(0, 1, 0, 32'h10, 1, 0, 0, 0, 0, 32'd0, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'd0, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'd0, 0);
    vecs[6]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'd0, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 32'd0, 0);
    vecs[8]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 32'd4, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 32'd5, 0);
    vecs[10] = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 32'd6, 0);
    vecs[11] = mk(0, 0, 0, 32'h0,  1, 0, 0, 1, 1, 32'd7, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,  1, 1, 0, 0, 0, 32'd0, 0);

    for (int i = 0; i < NVEC; i++) begin
      rst         = vecs[i].rst;
      req_valid   = vecs[i].req_valid;
      req_write   = vecs[i].req_write;
      req_addr    = vecs[i].req_addr;
      rdata_ready = vecs[i].rdata_ready;
      wdata_valid = 1'b0;
      step();
      check($sformatf("vec%0d_req_ready", i),   32'(req_ready),   32'(vecs[i].e_req_ready));
      check($sformatf("vec%0d_wdata_ready", i), 32'(wdata_ready), 32'(vecs[i].e_wdata_ready));
      check($sformatf("vec%0d_rdata_valid", i), 32'(rdata_valid), 32'(vecs[i].e_rdata_valid));
      check($sformatf("vec%0d_rdata_last", i),  32'(rdata_last),  32'(vecs[i].e_rdata_last));
      check($sformatf("vec%0d_wr_done", i),     32'(wr_done),     32'(vecs[i].e_wr_done));
      if (vecs[i].e_rdata_valid || vecs[i].rst)
        check($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
    end
    req_valid = 1'b0;

    // Backpressure: beat 1 stalled for three cycles.
    exp_line = '{32'd4, 32'd5, 32'd6, 32'd7};
    read_line(32'h0000_0010, exp_line, 1, 3, 1'b0);

    // Writeback to line 2 (offset bits set in the address), then readback.
    a_line = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    write_line(32'h0000_0024, a_line);
    read_line(32'h0000_0020, a_line, -1, 0, 1'b0);

    // Aliased address maps to line 1; a req_valid pulse mid-burst is ignored.
    read_line(32'h0000_1010, exp_line, -1, 0, 1'b1);

    // Reset together with a request: reset wins, nothing is accepted.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_0010;
    step();
    check_reset_outs("rst_req");
    rst       = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      step();
      check("rst_req_no_burst", 32'(rdata_valid), 32'd0);
      check("rst_req_idle",     32'(req_ready),   32'd1);
    end

    // Reset in the middle of a writeback to line 3 after two beats.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_0030;
    step();
    req_valid = 1'b0;
    req_write = 1'b0;
    for (int b = 0; b < 2; b++) begin
      check("mid_wdata_ready", 32'(wdata_ready), 32'd1);
      wdata       = 32'hB000_0000 + 32'(b);
      wdata_valid = 1'b1;
      step();
    end
    wdata_valid = 1'b0;
    rst = 1'b1;
    step();
    check_reset_outs("mid_rst");
    rst = 1'b0;
    step();
    check("mid_rst_idle", 32'(req_ready), 32'd1);
    exp_line = '{32'hB000_0000, 32'hB000_0001, 32'd14, 32'd15};
    read_line(32'h0000_0030, exp_line, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
